// File: rtl/sdram_pkg.sv
// sdram_pkg: shared widths and the ls responder state encoding
package sdram_pkg;
  localparam int LS_ADDR_W = 25;
  localparam int SDRAM_WORD_W = 16;
  typedef enum logic [2:0] {
    LS_IDLE, LS_WR_LO, LS_WR_HI, LS_RD_LO, LS_RD_LO_WAIT, LS_RD_HI, LS_RD_HI_WAIT
  } ls_state_t;
endpackage

// File: rtl/sdram_ls_resp.sv
// sdram_ls_resp: toggle req/ack low-speed port responder issuing 16-bit beats to the sequencer
module sdram_ls_resp
  import sdram_pkg::*;
#(
  parameter int ADDR_W = LS_ADDR_W,
  parameter int DATA_W = 2 * SDRAM_WORD_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_W-1:0]       ls_addr,
  input  logic [DATA_W-1:0]       ls_din,
  input  logic                    ls_wide,
  input  logic                    ls_we_req,
  output logic                    ls_we_ack,
  input  logic                    ls_rd_req,
  output logic                    ls_rd_ack,
  output logic [DATA_W-1:0]       ls_dout,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [SDRAM_WORD_W-1:0] mem_wdata,
  input  logic                    mem_gnt,
  input  logic                    mem_rvalid,
  input  logic [SDRAM_WORD_W-1:0] mem_rdata
);
  localparam int W = SDRAM_WORD_W;
  ls_state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, maddr_q, maddr_d;
  logic [W-1:0] din_hi_q, din_hi_d, lo_q, lo_d, wdata_q, wdata_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic wide_q, wide_d, we_ack_q, we_ack_d, rd_ack_q, rd_ack_d, req_q, req_d, we_q, we_d;
  logic we_pend, rd_pend, gnt;
  logic [ADDR_W-1:0] addr_al, addr_hi;
  assign we_pend = ls_we_req ^ we_ack_q;
  assign rd_pend = ls_rd_req ^ rd_ack_q;
  assign gnt = req_q & mem_gnt;
  assign addr_al = ls_addr & ~ADDR_W'(1);
  assign addr_hi = addr_q + ADDR_W'(2);
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    din_hi_d = din_hi_q;
    wide_d = wide_q;
    lo_d = lo_q;
    dout_d = dout_q;
    we_ack_d = we_ack_q;
    rd_ack_d = rd_ack_q;
    req_d = req_q;
    we_d = we_q;
    maddr_d = maddr_q;
    wdata_d = wdata_q;
    case (state_q)
      LS_IDLE: begin
        // writes take priority; a simultaneous read stays pending
        if (we_pend || rd_pend) begin
          state_d = we_pend ? LS_WR_LO : LS_RD_LO;
          addr_d = addr_al;
          din_hi_d = ls_din[DATA_W-1:W];
          wide_d = ls_wide;
          req_d = 1'b1;
          we_d = we_pend;
          maddr_d = addr_al;
          wdata_d = we_pend ? ls_din[W-1:0] : wdata_q;
        end
      end
      LS_WR_LO: if (gnt) begin
        state_d = wide_q ? LS_WR_HI : LS_IDLE;
        req_d = wide_q;
        maddr_d = wide_q ? addr_hi : maddr_q;
        wdata_d = wide_q ? din_hi_q : wdata_q;
        we_ack_d = wide_q ? we_ack_q : ~we_ack_q;
      end
      LS_WR_HI: if (gnt) begin
        state_d = LS_IDLE;
        req_d = 1'b0;
        we_ack_d = ~we_ack_q;
      end
      LS_RD_LO: if (gnt) begin
        state_d = LS_RD_LO_WAIT;
        req_d = 1'b0;
      end
      LS_RD_LO_WAIT: if (mem_rvalid) begin
        state_d = wide_q ? LS_RD_HI : LS_IDLE;
        lo_d = mem_rdata;
        req_d = wide_q;
        maddr_d = wide_q ? addr_hi : maddr_q;
        dout_d = wide_q ? dout_q : {{(DATA_W-W){1'b0}}, mem_rdata};
        rd_ack_d = wide_q ? rd_ack_q : ~rd_ack_q;
      end
      LS_RD_HI: if (gnt) begin
        state_d = LS_RD_HI_WAIT;
        req_d = 1'b0;
      end
      LS_RD_HI_WAIT: if (mem_rvalid) begin
        state_d = LS_IDLE;
        dout_d = {mem_rdata, lo_q};
        rd_ack_d = ~rd_ack_q;
      end
      default: state_d = LS_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= LS_IDLE;
      addr_q <= '0;
      din_hi_q <= '0;
      wide_q <= 1'b0;
      lo_q <= '0;
      dout_q <= '0;
      we_ack_q <= 1'b0;
      rd_ack_q <= 1'b0;
      req_q <= 1'b0;
      we_q <= 1'b0;
      maddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      din_hi_q <= din_hi_d;
      wide_q <= wide_d;
      lo_q <= lo_d;
      dout_q <= dout_d;
      we_ack_q <= we_ack_d;
      rd_ack_q <= rd_ack_d;
      req_q <= req_d;
      we_q <= we_d;
      maddr_q <= maddr_d;
      wdata_q <= wdata_d;
    end
  end
  assign ls_we_ack = we_ack_q;
  assign ls_rd_ack = rd_ack_q;
  assign ls_dout = dout_q;
  assign mem_req = req_q;
  assign mem_we = we_q;
  assign mem_addr = maddr_q;
  assign mem_wdata = wdata_q;
endmodule

// File: tb/tb_sdram_ls_resp.sv
// tb_sdram_ls_resp: directed scenario tests for the ls toggle responder
module tb_sdram_ls_resp;
  logic clk = 1'b0;
  logic reset;
  logic [24:0] ls_addr;
  logic [31:0] ls_din;
  logic ls_wide, ls_we_req, ls_rd_req, mem_gnt, mem_rvalid;
  logic [15:0] mem_rdata;
  logic ls_we_ack, ls_rd_ack, mem_req, mem_we;
  logic [31:0] ls_dout;
  logic [24:0] mem_addr;
  logic [15:0] mem_wdata;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  sdram_ls_resp dut (
    .clk(clk), .reset(reset), .ls_addr(ls_addr), .ls_din(ls_din), .ls_wide(ls_wide),
    .ls_we_req(ls_we_req), .ls_we_ack(ls_we_ack), .ls_rd_req(ls_rd_req), .ls_rd_ack(ls_rd_ack),
    .ls_dout(ls_dout), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  task automatic test_reset();
    reset = 1'b1; ls_addr = '0; ls_din = '0; ls_wide = 0; ls_we_req = 0; ls_rd_req = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
    repeat (3) @(negedge clk);
    total++;
    if ({ls_we_ack, ls_rd_ack, mem_req, mem_we} !== 4'b0000) begin
      bad++; $display("FAIL rst_flags got=%b exp=0000", {ls_we_ack, ls_rd_ack, mem_req, mem_we});
    end
    total++;
    if ({ls_dout, mem_addr, mem_wdata} !== 73'h0) begin
      bad++; $display("FAIL rst_data got dout=%h addr=%h wdata=%h exp=0", ls_dout, mem_addr, mem_wdata);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (mem_req !== 1'b0) begin bad++; $display("FAIL rst_idle_req got=%b exp=0", mem_req); end
  endtask

  task automatic test_wide_write();
    mem_gnt = 1; ls_addr = 25'h0100000; ls_din = 32'hDEADBEEF; ls_wide = 1; ls_we_req = ~ls_we_req;
    @(negedge clk);
    ls_addr = 25'h1555555; ls_din = 32'h0; ls_wide = 0;
    total++;
    if ({mem_req, mem_we, mem_addr, mem_wdata} !== {2'b11, 25'h0100000, 16'hBEEF}) begin
      bad++; $display("FAIL ww_beat0 got req=%b we=%b addr=%h data=%h exp 1 1 0100000 beef", mem_req, mem_we, mem_addr, mem_wdata);
    end
    total++;
    if (ls_we_ack === ls_we_req) begin bad++; $display("FAIL ww_early_ack got=%b exp=%b", ls_we_ack, ~ls_we_req); end
    @(negedge clk);
    total++;
    if ({mem_req, mem_we, mem_addr, mem_wdata} !== {2'b11, 25'h0100002, 16'hDEAD}) begin
      bad++; $display("FAIL ww_beat1 got req=%b we=%b addr=%h data=%h exp 1 1 0100002 dead", mem_req, mem_we, mem_addr, mem_wdata);
    end
    total++;
    if (ls_we_ack === ls_we_req) begin bad++; $display("FAIL ww_ack_c2 got=%b exp=%b", ls_we_ack, ~ls_we_req); end
    @(negedge clk);
    total++;
    if (ls_we_ack !== ls_we_req) begin bad++; $display("FAIL ww_ack_c3 got=%b exp=%b", ls_we_ack, ls_we_req); end
    total++;
    if (mem_req !== 1'b0) begin bad++; $display("FAIL ww_req_drop got=%b exp=0", mem_req); end
  endtask

  task automatic test_narrow_read();
    mem_gnt = 0; ls_addr = 25'h0040200; ls_wide = 0; ls_rd_req = ~ls_rd_req;
    @(negedge clk);
    total++;
    if ({mem_req, mem_we, mem_addr} !== {2'b10, 25'h0040200}) begin
      bad++; $display("FAIL nr_beat got req=%b we=%b addr=%h exp 1 0 0040200", mem_req, mem_we, mem_addr);
    end
    mem_gnt = 1;
    @(negedge clk);
    mem_gnt = 0;
    total++;
    if (mem_req !== 1'b0) begin bad++; $display("FAIL nr_req_drop got=%b exp=0", mem_req); end
    repeat (3) @(negedge clk);
    total++;
    if (ls_rd_ack === ls_rd_req) begin bad++; $display("FAIL nr_early_ack got=%b exp=%b", ls_rd_ack, ~ls_rd_req); end
    mem_rvalid = 1; mem_rdata = 16'h1234;
    @(negedge clk);
    mem_rvalid = 0;
    total++;
    if (ls_dout !== 32'h00001234) begin bad++; $display("FAIL nr_dout got=%h exp=00001234", ls_dout); end
    total++;
    if (ls_rd_ack !== ls_rd_req) begin bad++; $display("FAIL nr_ack got=%b exp=%b", ls_rd_ack, ls_rd_req); end
  endtask

  task automatic test_simultaneous();
    mem_gnt = 1; ls_addr = 25'h0200000; ls_din = 32'h0000A5A5; ls_wide = 0;
    ls_we_req = ~ls_we_req; ls_rd_req = ~ls_rd_req;
    @(negedge clk);
    ls_addr = 25'h0000345;
    total++;
    if ({mem_req, mem_we, mem_addr, mem_wdata} !== {2'b11, 25'h0200000, 16'hA5A5}) begin
      bad++; $display("FAIL sim_wbeat got req=%b we=%b addr=%h data=%h exp 1 1 0200000 a5a5", mem_req, mem_we, mem_addr, mem_wdata);
    end
    @(negedge clk);
    total++;
    if ({ls_we_ack === ls_we_req, ls_rd_ack === ls_rd_req} !== 2'b10) begin
      bad++; $display("FAIL sim_order got we_done=%b rd_done=%b exp 1 0", ls_we_ack === ls_we_req, ls_rd_ack === ls_rd_req);
    end
    @(negedge clk);
    total++;
    if ({mem_req, mem_we, mem_addr} !== {2'b10, 25'h0000344}) begin
      bad++; $display("FAIL sim_rbeat got req=%b we=%b addr=%h exp 1 0 0000344", mem_req, mem_we, mem_addr);
    end
    @(negedge clk);
    mem_rvalid = 1; mem_rdata = 16'h5A5A;
    @(negedge clk);
    mem_rvalid = 0;
    total++;
    if ({ls_rd_ack === ls_rd_req, ls_dout} !== {1'b1, 32'h00005A5A}) begin
      bad++; $display("FAIL sim_read got done=%b dout=%h exp 1 00005a5a", ls_rd_ack === ls_rd_req, ls_dout);
    end
  endtask

  task automatic test_wrap_stall();
    mem_gnt = 0; ls_addr = 25'h1FFFFFE; ls_din = 32'h12345678; ls_wide = 1; ls_we_req = ~ls_we_req;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      mem_rvalid = (i == 2);
      total++;
      if ({mem_req, mem_we, mem_addr, mem_wdata} !== {2'b11, 25'h1FFFFFE, 16'h5678}) begin
        bad++; $display("FAIL wrap_stall%0d got req=%b we=%b addr=%h data=%h exp 1 1 1fffffe 5678", i, mem_req, mem_we, mem_addr, mem_wdata);
      end
    end
    mem_rvalid = 0; mem_gnt = 1;
    @(negedge clk);
    mem_gnt = 0;
    total++;
    if ({mem_req, mem_addr, mem_wdata} !== {1'b1, 25'h0000000, 16'h1234}) begin
      bad++; $display("FAIL wrap_beat1 got req=%b addr=%h data=%h exp 1 0000000 1234", mem_req, mem_addr, mem_wdata);
    end
    @(negedge clk);
    total++;
    if ({mem_req, ls_we_ack === ls_we_req} !== 2'b10) begin
      bad++; $display("FAIL wrap_hold got req=%b done=%b exp 1 0", mem_req, ls_we_ack === ls_we_req);
    end
    mem_gnt = 1;
    @(negedge clk);
    total++;
    if ({mem_req, ls_we_ack === ls_we_req} !== 2'b01) begin
      bad++; $display("FAIL wrap_done got req=%b done=%b exp 0 1", mem_req, ls_we_ack === ls_we_req);
    end
  endtask

  task automatic test_reset_mid();
    mem_gnt = 1; ls_addr = 25'h0000100; ls_wide = 1; ls_rd_req = ~ls_rd_req;
    @(negedge clk);
    @(negedge clk);
    mem_rvalid = 1; mem_rdata = 16'h1111;
    @(negedge clk);
    mem_rvalid = 0;
    total++;
    if ({mem_req, mem_we, mem_addr} !== {2'b10, 25'h0000102}) begin
      bad++; $display("FAIL rm_hibeat got req=%b we=%b addr=%h exp 1 0 0000102", mem_req, mem_we, mem_addr);
    end
    @(negedge clk);
    reset = 1; ls_rd_req = 0; ls_we_req = 0; mem_gnt = 0;
    @(negedge clk);
    reset = 0; mem_rvalid = 1; mem_rdata = 16'h2222;
    @(negedge clk);
    mem_rvalid = 0;
    total++;
    if ({ls_we_ack, ls_rd_ack, mem_req} !== 3'b000) begin
      bad++; $display("FAIL rm_flags got we_ack=%b rd_ack=%b req=%b exp 000", ls_we_ack, ls_rd_ack, mem_req);
    end
    total++;
    if (ls_dout !== 32'h0) begin bad++; $display("FAIL rm_dout got=%h exp=00000000", ls_dout); end
    repeat (2) @(negedge clk);
    total++;
    if ({mem_req, ls_rd_ack} !== 2'b00) begin
      bad++; $display("FAIL rm_quiet got req=%b rd_ack=%b exp 00", mem_req, ls_rd_ack);
    end
  endtask

  task automatic test_stream();
    int beats = 0;
    int cyc = 0;
    for (int i = 0; i < 128; i++) begin
      int cnt = 0;
      bit done = 0;
      ls_addr = 25'h0300000 + 25'(2 * i); ls_din = {16'hFFFF, 16'hC000 + 16'(i)}; ls_wide = 0;
      ls_we_req = ~ls_we_req;
      while (!done && cnt < 20) begin
        @(negedge clk);
        cnt++;
        if (ls_we_ack === ls_we_req) done = 1;
        else begin
          mem_gnt = (cyc % 3) != 2;
          cyc++;
          if (mem_req && mem_gnt) begin
            total++;
            if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 25'h0300000 + 25'(2 * i), 16'hC000 + 16'(i)}) begin
              bad++; $display("FAIL st_beat%0d got we=%b addr=%h data=%h exp 1 %h %h", i, mem_we, mem_addr, mem_wdata, 25'h0300000 + 25'(2 * i), 16'hC000 + 16'(i));
            end
            beats++;
          end
        end
      end
      total++;
      if (!done) begin bad++; $display("FAIL st_ack%0d got=%b exp=%b (timeout)", i, ls_we_ack, ls_we_req); end
    end
    total++;
    if (beats != 128) begin bad++; $display("FAIL st_count got=%0d exp=128", beats); end
  endtask

  initial begin
    test_reset();
    test_wide_write();
    test_narrow_read();
    test_simultaneous();
    test_wrap_stall();
    test_reset_mid();
    test_stream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
